// File: rtl/bin_to_bcd_scan_if.sv
// Request/result bundle between a binary source, the BCD converter and the 7-segment scanner.
// The master drives start/bin. The slave (converter) drives status and display outputs.
interface bin_to_bcd_scan_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIGITS = 3
) ();
    logic                  start;
    logic [DATA_W-1:0]     bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_all;
    logic [3:0]            bcd;
    logic                  mode;
    logic [DIGITS-1:0]     dig_sel;

    modport master (
        output start, bin,
        input  busy, done, bcd_all, bcd, mode, dig_sel
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd_all, bcd, mode, dig_sel
    );
endinterface

// File: rtl/bin_to_bcd_scan.sv
// Iterative double-dabble binary-to-BCD converter with a held display register and a
// free-running one-hot digit scanner feeding a 7-segment decoder.
module bin_to_bcd_scan #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic             clk,
    input logic             rst_n,
    bin_to_bcd_scan_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]  scratch_q, scratch_d;
    logic [BCD_W-1:0]  adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BCD_W-1:0]  bcd_all_q, bcd_all_d;
    logic              valid_q, valid_d;

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [3:0]        bcd_q, bcd_d;

    // Per-nibble add-3 correction; nibbles never carry into each other.
    always_comb begin
        adj = scratch_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_all_d = bcd_all_q;
        valid_d   = valid_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(DATA_W);
                    state_d   = StShift;
                end
            end
            StShift: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                // Display register is loaded on the last shift so it is valid during done.
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = StDone;
                    bcd_all_d = scratch_d;
                    valid_d   = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        dig_sel_d = '0;
        bcd_d     = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                dig_sel_d[i] = 1'b1;
                bcd_d        = bcd_all_q[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_all_q <= '0;
            valid_q   <= 1'b0;
            presc_q   <= '0;
            idx_q     <= '0;
            dig_sel_q <= DIGITS'(1);
            bcd_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_all_q <= bcd_all_d;
            valid_q   <= valid_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            dig_sel_q <= dig_sel_d;
            bcd_q     <= bcd_d;
        end
    end

    assign bus.busy    = (state_q == StShift);
    assign bus.done    = (state_q == StDone);
    assign bus.bcd_all = bcd_all_q;
    assign bus.bcd     = bcd_q;
    assign bus.mode    = valid_q;
    assign bus.dig_sel = dig_sel_q;
endmodule

// File: tb/tb_bin_to_bcd_scan.sv
// Directed bench for bin_to_bcd_scan: async reset, conversion latency, ignored starts,
// digit scanning and mid-conversion reset, with hand-computed BCD results.
module tb_bin_to_bcd_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_scan_if #(.DATA_W(8), .DIGITS(3)) bus_if ();

    bin_to_bcd_scan #(
        .DATA_W   (8),
        .DIGITS   (3),
        .SCAN_DIV (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(bus_if.busy), 0);
        chk({tag, "_done"}, 32'(bus_if.done), 0);
        chk({tag, "_mode"}, 32'(bus_if.mode), 0);
        chk({tag, "_dig_sel"}, 32'(bus_if.dig_sel), 32'h1);
        chk({tag, "_bcd"}, 32'(bus_if.bcd), 0);
        chk({tag, "_bcd_all"}, 32'(bus_if.bcd_all), 32'h000);
    endtask

    // Start from IDLE, check the 8 busy cycles, the single done cycle and the cycle after.
    task automatic convert(input logic [7:0] v, input logic [11:0] exp, input logic [11:0] old,
                           input logic old_mode, input int inject_at);
        bus_if.bin   = v;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("busy", 32'(bus_if.busy), 1);
            chk("done_early", 32'(bus_if.done), 0);
            chk("bcd_all_hold", 32'(bus_if.bcd_all), 32'(old));
            chk("mode_hold", 32'(bus_if.mode), 32'(old_mode));
            if (i == inject_at) begin
                bus_if.bin   = 8'd42;
                bus_if.start = 1'b1;
            end else begin
                bus_if.start = 1'b0;
            end
            tick();
        end
        bus_if.start = 1'b0;
        chk("busy_end", 32'(bus_if.busy), 0);
        chk("done", 32'(bus_if.done), 1);
        chk("bcd_all", 32'(bus_if.bcd_all), 32'(exp));
        chk("mode", 32'(bus_if.mode), 1);
        tick();
        chk("done_pulse", 32'(bus_if.done), 0);
        chk("busy_after", 32'(bus_if.busy), 0);
        chk("bcd_all_kept", 32'(bus_if.bcd_all), 32'(exp));
    endtask

    initial begin
        logic [2:0]  prev_sel;
        logic        found;
        logic [2:0]  sel_seq [4];
        logic [3:0]  bcd_seq [4];

        bus_if.start = 1'b0;
        bus_if.bin   = 8'd0;

        // 1: asynchronous reset asserted between clock edges
        tick();
        tick();
        #6;
        rst_n = 1'b0;
        #1;
        chk_reset_values("rst_async");
        tick();
        tick();
        chk_reset_values("rst_held");
        #3;
        rst_n = 1'b1;
        tick();

        // 2: 255 with mode turning on at the first done
        convert(8'd255, 12'h255, 12'h000, 1'b0, 0);

        // 5: scan order and hold time once 255 is displayed
        sel_seq[0] = 3'b001; sel_seq[1] = 3'b010; sel_seq[2] = 3'b100; sel_seq[3] = 3'b001;
        bcd_seq[0] = 4'd5;   bcd_seq[1] = 4'd5;   bcd_seq[2] = 4'd2;   bcd_seq[3] = 4'd5;
        found    = 1'b0;
        prev_sel = bus_if.dig_sel;
        for (int n = 0; n < 30 && !found; n++) begin
            tick();
            if (prev_sel == 3'b100 && bus_if.dig_sel == 3'b001) found = 1'b1;
            prev_sel = bus_if.dig_sel;
        end
        chk("scan_sync", 32'(found), 1);
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 4; c++) begin
                chk("scan_sel", 32'(bus_if.dig_sel), 32'(sel_seq[j]));
                chk("scan_bcd", 32'(bus_if.bcd), 32'(bcd_seq[j]));
                if (j < 3 || c < 3) tick();
            end
        end
        tick();

        // 3: back-to-back conversions
        convert(8'd0, 12'h000, 12'h255, 1'b1, 0);
        convert(8'd109, 12'h109, 12'h000, 1'b1, 0);
        convert(8'd99, 12'h099, 12'h109, 1'b1, 0);

        // 4: start with 42 during conversion of 200 is ignored
        convert(8'd200, 12'h200, 12'h099, 1'b1, 3);
        for (int n = 0; n < 10; n++) begin
            chk("no_second_done", 32'(bus_if.done), 0);
            chk("no_second_busy", 32'(bus_if.busy), 0);
            tick();
        end
        chk("bcd_all_200", 32'(bus_if.bcd_all), 32'h200);

        // 6: reset during the fourth SHIFT cycle aborts the conversion
        bus_if.bin   = 8'd123;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_busy_pre", 32'(bus_if.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("rst_mid");
        #1;
        rst_n = 1'b1;
        tick();
        for (int n = 0; n < 12; n++) begin
            chk("abort_no_done", 32'(bus_if.done), 0);
            chk("abort_no_busy", 32'(bus_if.busy), 0);
            tick();
        end
        chk("abort_mode", 32'(bus_if.mode), 0);
        convert(8'd7, 12'h007, 12'h000, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
